// File: rtl/pr_window_packer.sv
// Fetches RGB pixels from frame memory, converts them to gray and emits a 3x3 gray
// neighbourhood plus centre RGB per display pixel, aligned with 4-cycle-delayed VGA timing.
module pr_window_packer #(
  parameter int X0     = 100,
  parameter int Y0     = 100,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 115,
  parameter int ADDR_W = 15
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              blank,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [95:0]       dout,
  output logic              blank_o,
  output logic [9:0]        hc_o,
  output logic [9:0]        vc_o,
  output logic              frame_done
);

  localparam int         COL_W  = $clog2(IMG_W);
  localparam logic [9:0] X_LO   = 10'(X0);
  localparam logic [9:0] X_END  = 10'(X0 + IMG_W - 1);
  localparam logic [9:0] Y_FLO  = 10'(Y0 - 1);
  localparam logic [9:0] Y_LO   = 10'(Y0);
  localparam logic [9:0] Y_LAST = 10'(Y0 + IMG_H - 1);
  localparam logic [9:0] FR_MAX = 10'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [7:0] rgb_to_gray(input logic [23:0] rgb);
    logic [15:0] acc;
    acc = 16'd77 * {8'd0, rgb[23:16]} + 16'd150 * {8'd0, rgb[15:8]} + 16'd29 * {8'd0, rgb[7:0]};
    return 8'(acc >> 8);
  endfunction

  logic             col_in_s, fetch_s, disp_s, last_s, top_s;
  logic [COL_W-1:0] col_s;
  logic [9:0]       fr_s;

  logic             p1_fetch_r, p1_disp_r, p1_top_r, p1_last_r;
  logic [COL_W-1:0] p1_col_r;
  logic             p2_fetch_r, p2_disp_r, p2_top_r, p2_last_r;
  logic [COL_W-1:0] p2_col_r;
  logic [7:0]       gray_r;
  logic [23:0]      rgb_r;

  logic [7:0]       lb_prev_r [IMG_W];
  logic [7:0]       lb_cur_r  [IMG_W];
  logic [23:0]      rgb_cur_r [IMG_W];
  logic [7:0]       up_s, mid_s, dn_s;
  logic [23:0]      rgb_mid_s;

  logic [7:0]       s0_up_r, s0_mid_r, s0_dn_r, s1_up_r, s1_mid_r, s1_dn_r;
  logic [23:0]      s0_rgb_r;
  logic [COL_W-1:0] s0_col_r;
  logic             s0_disp_r, s0_last_r;
  logic [7:0]       l_up_s, l_mid_s, l_dn_s, r_up_s, r_mid_s, r_dn_s;
  logic [95:0]      dout_next_s;
  logic             done_s;

  logic [1:0]       state_r;
  logic [95:0]      dout_r;
  logic             frame_done_r;
  logic [3:0]       blank_d_r;
  logic [9:0]       hc_d_r [4];
  logic [9:0]       vc_d_r [4];

  // Window decode: fetch rows run one line ahead of the display rows they feed.
  always_comb begin
    col_in_s = (hc >= X_LO) && (hc <= X_END);
    fetch_s  = !blank && col_in_s && (vc >= Y_FLO) && (vc < Y_LAST);
    disp_s   = !blank && col_in_s && (vc >= Y_LO) && (vc <= Y_LAST);
    last_s   = disp_s && (vc == Y_LAST) && (hc == X_END);
    top_s    = fetch_s && (vc == Y_FLO);
    col_s    = COL_W'(hc - X_LO);
    fr_s     = ((vc - Y_FLO) > FR_MAX) ? FR_MAX : (vc - Y_FLO);
  end

  // Memory request is combinational so the read lands in time for the 4-cycle alignment.
  always_comb begin
    if (reset && fetch_s) begin
      mem_en   = 1'b1;
      mem_addr = ADDR_W'(fr_s) * ADDR_W'(IMG_W) + ADDR_W'(col_s);
    end else begin
      mem_en   = 1'b0;
      mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Position pipeline, gray conversion and timing delay line.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      {p1_fetch_r, p1_disp_r, p1_top_r, p1_last_r} <= 4'd0;
      {p2_fetch_r, p2_disp_r, p2_top_r, p2_last_r} <= 4'd0;
      p1_col_r  <= {COL_W{1'b0}};
      p2_col_r  <= {COL_W{1'b0}};
      gray_r    <= 8'd0;
      rgb_r     <= 24'd0;
      blank_d_r <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        hc_d_r[i] <= 10'd0;
        vc_d_r[i] <= 10'd0;
      end
    end else begin
      {p1_fetch_r, p1_disp_r, p1_top_r, p1_last_r} <= {fetch_s, disp_s, top_s, last_s};
      p1_col_r  <= col_s;
      {p2_fetch_r, p2_disp_r, p2_top_r, p2_last_r} <= {p1_fetch_r, p1_disp_r, p1_top_r, p1_last_r};
      p2_col_r  <= p1_col_r;
      gray_r    <= rgb_to_gray(mem_rdata);
      rgb_r     <= mem_rdata;
      blank_d_r <= {blank_d_r[2:0], blank};
      hc_d_r[0] <= hc;
      vc_d_r[0] <= vc;
      for (int i = 1; i < 4; i++) begin
        hc_d_r[i] <= hc_d_r[i-1];
        vc_d_r[i] <= vc_d_r[i-1];
      end
    end
  end

  // Read-before-write column taps; the last row has no fetch, so its down row replicates itself.
  always_comb begin
    up_s      = lb_prev_r[p2_col_r];
    mid_s     = lb_cur_r[p2_col_r];
    rgb_mid_s = rgb_cur_r[p2_col_r];
    dn_s      = p2_fetch_r ? gray_r : mid_s;
  end

  // Line buffers; fetch row 0 also seeds the previous-row buffer for top replication.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb_prev_r[i] <= 8'd0;
        lb_cur_r[i]  <= 8'd0;
        rgb_cur_r[i] <= 24'd0;
      end
    end else if (p2_fetch_r) begin
      lb_prev_r[p2_col_r] <= p2_top_r ? gray_r : mid_s;
      lb_cur_r[p2_col_r]  <= gray_r;
      rgb_cur_r[p2_col_r] <= rgb_r;
    end
  end

  // Column shift: s0 is the centre column, s1 the one to its left, live taps the right.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      {s0_up_r, s0_mid_r, s0_dn_r, s1_up_r, s1_mid_r, s1_dn_r} <= 48'd0;
      s0_rgb_r  <= 24'd0;
      s0_col_r  <= {COL_W{1'b0}};
      s0_disp_r <= 1'b0;
      s0_last_r <= 1'b0;
    end else begin
      {s0_up_r, s0_mid_r, s0_dn_r} <= {up_s, mid_s, dn_s};
      {s1_up_r, s1_mid_r, s1_dn_r} <= {s0_up_r, s0_mid_r, s0_dn_r};
      s0_rgb_r  <= rgb_mid_s;
      s0_col_r  <= p2_col_r;
      s0_disp_r <= p2_disp_r;
      s0_last_r <= p2_last_r;
    end
  end

  // Edge replication and output word assembly.
  always_comb begin
    if (s0_col_r == {COL_W{1'b0}}) begin
      {l_up_s, l_mid_s, l_dn_s} = {s0_up_r, s0_mid_r, s0_dn_r};
    end else begin
      {l_up_s, l_mid_s, l_dn_s} = {s1_up_r, s1_mid_r, s1_dn_r};
    end
    if (s0_col_r == COL_LAST) begin
      {r_up_s, r_mid_s, r_dn_s} = {s0_up_r, s0_mid_r, s0_dn_r};
    end else begin
      {r_up_s, r_mid_s, r_dn_s} = {up_s, mid_s, dn_s};
    end
    done_s = (state_r == S_RUN) && s0_disp_r && s0_last_r;
    if ((state_r == S_RUN) && s0_disp_r) begin
      dout_next_s = {s0_mid_r, l_mid_s, r_mid_s, s0_up_r, s0_dn_r, l_up_s, l_dn_s,
                     r_up_s, r_dn_s, s0_rgb_r[7:0], s0_rgb_r[15:8], s0_rgb_r[23:16]};
    end else begin
      dout_next_s = 96'd0;
    end
  end

  // Frame sequencing and registered outputs.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_WAIT;
      dout_r       <= 96'd0;
      frame_done_r <= 1'b0;
    end else begin
      dout_r       <= dout_next_s;
      frame_done_r <= done_s;
      case (state_r)
        S_WAIT:  if (!blank && (vc == Y_FLO) && (hc == X_LO)) state_r <= S_FILL;
        S_FILL:  if (vc == Y_LO) state_r <= S_RUN;
        S_RUN:   if (done_s) state_r <= S_DONE;
        S_DONE:  if (vc == 10'd0) state_r <= S_WAIT;
        default: state_r <= S_WAIT;
      endcase
    end
  end

  assign dout       = dout_r;
  assign frame_done = frame_done_r;
  assign blank_o    = blank_d_r[3];
  assign hc_o       = hc_d_r[3];
  assign vc_o       = vc_d_r[3];

endmodule

// File: tb/tb_pr_window_packer.sv
// Randomized and directed bench for pr_window_packer against an image-level neighbourhood model.
module tb_pr_window_packer;

  localparam int X0 = 100, Y0 = 100, IMG_W = 160, IMG_H = 115, ADDR_W = 15;
  localparam int M_UNI = 0, M_RAND = 1, M_RAMP = 2, M_SINGLE = 3;

  logic              pixel_clk = 1'b0;
  logic              reset, blank;
  logic [9:0]        hc, vc;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_rdata = 24'd0;
  logic [95:0]       dout;
  logic              blank_o, frame_done;
  logic [9:0]        hc_o, vc_o;

  logic [23:0] img [IMG_W*IMG_H];
  int hist_h [5];
  int hist_v [5];
  bit hist_b [5];
  int checks, failures, mode;

  pr_window_packer #(.X0(X0), .Y0(Y0), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .pixel_clk(pixel_clk), .reset(reset), .blank(blank), .hc(hc), .vc(vc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dout(dout),
    .blank_o(blank_o), .hc_o(hc_o), .vc_o(vc_o), .frame_done(frame_done)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Frame memory: one-cycle read latency.
  always @(posedge pixel_clk) if (mem_en) mem_rdata <= img[mem_addr];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int x, input int hi);
    return (x < 0) ? 0 : ((x > hi) ? hi : x);
  endfunction

  function automatic logic [7:0] gray_at(input int r, input int c);
    logic [23:0] p;
    p = img[clampi(r, IMG_H-1) * IMG_W + clampi(c, IMG_W-1)];
    return 8'((77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256);
  endfunction

  function automatic logic [95:0] model(input int r, input int c);
    logic [23:0] p;
    p = img[r * IMG_W + c];
    return {gray_at(r, c), gray_at(r, c-1), gray_at(r, c+1), gray_at(r-1, c), gray_at(r+1, c),
            gray_at(r-1, c-1), gray_at(r+1, c-1), gray_at(r-1, c+1), gray_at(r+1, c+1),
            p[7:0], p[15:8], p[23:16]};
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 5; i++) begin
      hist_h[i] = 0; hist_v[i] = 0; hist_b[i] = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 96'd0);
    chk({tag, "_blank_o"}, {95'd0, blank_o}, 96'd1);
    chk({tag, "_hc_o"}, {86'd0, hc_o}, 96'd0);
    chk({tag, "_vc_o"}, {86'd0, vc_o}, 96'd0);
    chk({tag, "_frame_done"}, {95'd0, frame_done}, 96'd0);
    chk({tag, "_mem_en"}, {95'd0, mem_en}, 96'd0);
    chk({tag, "_mem_addr"}, {81'd0, mem_addr}, 96'd0);
  endtask

  task automatic reset_hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge pixel_clk);
      reset = 1'b0; hc = 10'd0; vc = 10'd0; blank = 1'b1;
      clear_hist();
      #1 check_reset_outputs("reset");
    end
    @(negedge pixel_clk);
    reset = 1'b1;
  endtask

  task automatic step(input int h, input int v, input bit b);
    int oh, ov, ea;
    bit ob, ee, in_img;
    logic [95:0] ed;
    @(negedge pixel_clk);
    hc = 10'(h); vc = 10'(v); blank = b;
    for (int i = 4; i > 0; i--) begin
      hist_h[i] = hist_h[i-1]; hist_v[i] = hist_v[i-1]; hist_b[i] = hist_b[i-1];
    end
    hist_h[0] = h; hist_v[0] = v; hist_b[0] = b;
    #1;
    ee = !b && h >= X0 && h < X0 + IMG_W && v >= Y0 - 1 && v < Y0 + IMG_H - 1;
    ea = ee ? (v - Y0 + 1) * IMG_W + (h - X0) : 0;
    chk("mem_en", {95'd0, mem_en}, {95'd0, ee});
    chk("mem_addr", {81'd0, mem_addr}, 96'(ea));
    if (h == X0 && v == Y0 - 1 && !b) begin
      chk("first_fetch_en", {95'd0, mem_en}, 96'd1);
      chk("first_fetch_addr", {81'd0, mem_addr}, 96'd0);
    end
    oh = hist_h[4]; ov = hist_v[4]; ob = hist_b[4];
    chk("hc_o", {86'd0, hc_o}, 96'(oh));
    chk("vc_o", {86'd0, vc_o}, 96'(ov));
    chk("blank_o", {95'd0, blank_o}, {95'd0, ob});
    in_img = !ob && oh >= X0 && oh < X0 + IMG_W && ov >= Y0 && ov < Y0 + IMG_H;
    ed = in_img ? model(ov - Y0, oh - X0) : 96'd0;
    chk("dout", dout, ed);
    chk("frame_done", {95'd0, frame_done},
        {95'd0, in_img && oh == X0 + IMG_W - 1 && ov == Y0 + IMG_H - 1});
    if (in_img && mode == M_UNI) chk("uniform", dout, {12{8'h80}});
    if (in_img && mode == M_RAND && oh == 150 && ov == 120) chk("latency", dout, model(20, 50));
    if (in_img && mode == M_RAMP && ov == 105) begin
      if (oh == 110) begin
        chk("ramp_gray", {88'd0, dout[95:88]}, 96'd10);
        chk("ramp_left", {88'd0, dout[87:80]}, 96'd9);
        chk("ramp_right", {88'd0, dout[79:72]}, 96'd11);
        chk("ramp_up", {88'd0, dout[71:64]}, 96'd10);
        chk("ramp_down", {88'd0, dout[63:56]}, 96'd10);
        chk("ramp_leftup", {88'd0, dout[55:48]}, 96'd9);
        chk("ramp_rightdown", {88'd0, dout[31:24]}, 96'd11);
      end
      if (oh == X0) chk("ramp_left_edge", {88'd0, dout[87:80]}, 96'd0);
      if (oh == X0 + IMG_W - 1) chk("ramp_right_edge", {88'd0, dout[79:72]}, 96'd159);
    end
    if (in_img && mode == M_SINGLE && oh == X0 && ov == Y0) begin
      chk("single_gray", {88'd0, dout[95:88]}, 96'd76);
      chk("single_up", {88'd0, dout[71:64]}, 96'd76);
      chk("single_leftup", {88'd0, dout[55:48]}, 96'd76);
      chk("single_rgb", {72'd0, dout[23:0]}, 96'h0000FF);
    end
  endtask

  // One frame: a blanked vc=0 line, then display lines; stop early when stop_v >= 0.
  task automatic run_frame(input int stop_v, input int stop_h);
    for (int h = 0; h < 10; h++) step(h, 0, 1'b1);
    for (int v = Y0 - 1; v < Y0 + IMG_H; v++) begin
      for (int h = X0 - 2; h < X0 + IMG_W + 4; h++) begin
        step(h, v, h >= X0 + IMG_W + 2);
        if (v == stop_v && h == stop_h) return;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; mode = M_UNI;
    reset = 1'b0; hc = 10'd0; vc = 10'd0; blank = 1'b1;
    clear_hist();
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = 24'h808080;
    reset_hold(10);
    run_frame(150, 180);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    reset_hold(10);

    mode = M_RAND;
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = 24'($urandom);
    run_frame(-1, -1);

    mode = M_RAMP;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r*IMG_W + c] = {8'(c), 8'(c), 8'(c)};
    run_frame(-1, -1);

    mode = M_SINGLE;
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = 24'd0;
    img[0] = 24'hFF0000;
    run_frame(-1, -1);
    for (int h = 0; h < 6; h++) step(h, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pr_window_packer.md
Name: pr_window_packer

Overview:
- Producer of the 96-bit `dout` neighbourhood word consumed by the PR-region edge/filter operators.
- Fetches 24-bit RGB pixels from the image frame memory and converts each to 8-bit gray.
- Keeps two gray line buffers and one RGB line buffer, then emits, per display pixel, the 3x3 gray neighbourhood plus the centre pixel's RGB.
- Emits delayed `blank_o`/`hc_o`/`vc_o` so downstream operators see timing aligned with `dout`.

Parameters:
- X0, 100, first active display column of the image window
- Y0, 100, first active display row of the image window
- IMG_W, 160, image width in pixels
- IMG_H, 115, image height in pixels
- ADDR_W, 15, frame memory address width

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- blank  in  1  VGA blanking, 1 = blanked
- hc  in  10  VGA horizontal counter
- vc  in  10  VGA vertical counter
- mem_en  out  1  frame memory read enable
- mem_addr  out  ADDR_W  frame memory read address, row-major = row*IMG_W+col
- mem_rdata  in  24  {R[23:16],G[15:8],B[7:0]}, valid exactly 1 cycle after mem_en
- dout  out  96  {gray,left,right,up,down,leftup,leftdown,rightup,rightdown,blue,green,red}, 8 bits each, MSB first
- blank_o  out  1  blank delayed 4 cycles
- hc_o  out  10  hc delayed 4 cycles
- vc_o  out  10  vc delayed 4 cycles
- frame_done  out  1  one-cycle pulse when the last image pixel is emitted

Behaviour:
- Reset (reset=0) clears all registers and line buffers. Outputs: dout=0, mem_en=0, mem_addr=0, blank_o=1, hc_o=0, vc_o=0, frame_done=0. FSM enters S_WAIT.
- Fetch window: blank=0, X0<=hc<X0+IMG_W, Y0-1<=vc<Y0+IMG_H-1.
  - Inside it: mem_en=1, col=hc-X0, fetch row fr=vc-Y0+1, clamped to IMG_H-1.
  - Outside it: mem_en=0.
- Gray conversion: (77*R+150*G+29*B)>>8, 16-bit intermediate, registered one cycle after mem_rdata.
- Line buffer update for fetched gray/RGB at column c, with read-before-write in the same cycle:
  - lb_prev[c] <= lb_cur[c]
  - lb_cur[c] <= gray
  - rgb_cur[c] <= RGB
  - When fr=0, gray is also written to lb_prev[c] (top-row replication).
- Neighbourhood for display row r, column c: centre/left/right from lb_cur, up row from lb_prev, down row from row r+1 as it streams in. Each row passes through a 3-deep column shift register.
- Edge replication:
  - c=0: left-column taps take the centre-column values.
  - c=IMG_W-1: right-column taps take the centre-column values.
  - r=0: up row equals row 0.
  - r=IMG_H-1: down row equals row IMG_H-1 (clamped fetch).
- dout RGB fields carry the centre pixel: blue[23:16], green[15:8], red[7:0].
- Latency: fetch of column c at cycle t produces dout for column c at t+4. Equivalently, dout is registered in the cycle where hc_o=X0+c and vc_o=Y0+r. Pipeline is fixed at 4.
- dout=0 whenever the delayed position is outside the image window or blank_o=1.
- FSM:
  - S_WAIT -> S_FILL on vc=Y0-1, hc=X0, blank=0.
  - S_FILL (row 0 preload, no valid dout) -> S_RUN at vc=Y0.
  - S_RUN -> S_DONE after the output with vc_o=Y0+IMG_H-1, hc_o=X0+IMG_W-1; frame_done=1 for that cycle.
  - S_DONE -> S_WAIT when vc=0.
  - dout is forced to 0 in all states except S_RUN.
- Reset mid-frame: immediate clear. No valid dout until the next frame's S_FILL completes; frame_done is not pulsed for the aborted frame.
- blank toggling inside the fetch window suppresses fetches; those buffer columns are not updated.

Test Plan:
- Reset held low 10 cycles, then released at vc=0 -> dout=0, blank_o=1, mem_en=0 until vc=Y0-1, hc=X0. Then mem_en=1 with mem_addr=0.
- Uniform frame, every pixel R=G=B=0x80 -> every in-window dout={9x 0x80,0x80,0x80,0x80}, including all edge pixels.
- Memory returns gray ramp G=col (R=B=col): at r=5, c=10 -> gray=10, left=9, right=11, up/down=10, leftup=9, rightdown=11. At c=0 -> left=0. At c=159 -> right=159.
- Pixel (0,0)=RGB(255,0,0), rest 0 -> dout at hc_o=100, vc_o=100: gray=76, up=76, leftup=76, red=255, green=0, blue=0.
- Latency check: fetch with hc=150, vc=120 -> dout for col 50, row 20 appears exactly 4 cycles later with hc_o=150, vc_o=120.
- Reset asserted at vc=150 mid-frame -> outputs cleared within the same cycle (async). No frame_done pulse. Next frame produces a correct full image and frame_done at hc_o=259, vc_o=214.
